// File: rtl/wb_rr_arbiter.sv
// N-master Wishbone arbiter: round-robin or fixed-priority grant, the grant
// is held for the owner's whole cyc (bursts never split), and a per-strobe
// watchdog forces an error onto hung slave accesses.
module wb_rr_arbiter #(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int SEL_W     = 2,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [N_MASTERS-1:0]          i_wb_cyc,
  input  logic [N_MASTERS-1:0]          i_wb_stb,
  input  logic [N_MASTERS-1:0]          i_wb_we,
  input  logic [N_MASTERS-1:0]          i_wb_4_burst,
  input  logic [N_MASTERS-1:0]          i_wb_8_burst,
  input  logic [N_MASTERS*ADDR_W-1:0]   i_wb_adr,
  input  logic [N_MASTERS*DATA_W-1:0]   i_wb_o_dat,
  input  logic [N_MASTERS*SEL_W-1:0]    i_wb_sel,
  output logic [N_MASTERS-1:0]          o_wb_ack,
  output logic [N_MASTERS-1:0]          o_wb_err,
  output logic                          owb_cyc,
  output logic                          owb_stb,
  output logic                          owb_we,
  output logic                          owb_4_burst,
  output logic                          owb_8_burst,
  output logic [ADDR_W-1:0]             owb_adr,
  output logic [DATA_W-1:0]             owb_o_dat,
  output logic [SEL_W-1:0]              owb_sel,
  input  logic                          owb_ack,
  input  logic                          owb_err,
  output logic [N_MASTERS-1:0]          o_grant,
  output logic                          o_timeout
);

  localparam int IW = $clog2(N_MASTERS);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic          vld_q, vld_d;
  logic [IW-1:0] own_q, own_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] wd_q, wd_d;

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic          own_cyc;
  logic          wd_fire;

  assign own_cyc = i_wb_cyc[own_q];
  assign wd_fire = (TIMEOUT != 0) && vld_q && (wd_q == CW'(TIMEOUT));

  // Winner search; loops run backwards so the last hit is the first in search order
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    if (PRIO_MODE != 0) begin
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
        if (i_wb_cyc[i]) begin
          win_found = 1'b1;
          win_idx   = IW'(i);
        end
      end
    end else begin
      for (int k = N_MASTERS; k >= 1; k--) begin
        if (i_wb_cyc[(int'(last_q) + k) % N_MASTERS]) begin
          win_found = 1'b1;
          win_idx   = IW'((int'(last_q) + k) % N_MASTERS);
        end
      end
    end
  end

  // Grant hold/release: re-arbitrate only when idle or the owner drops cyc
  always_comb begin
    vld_d  = vld_q;
    own_d  = own_q;
    last_d = last_q;
    if (!vld_q || !own_cyc) begin
      vld_d = win_found;
      if (win_found) begin
        own_d  = win_idx;
        last_d = win_idx;
      end
    end
  end

  // Watchdog counts stalled strobe cycles; any termination, stb drop, release or fire clears it
  always_comb begin
    wd_d = '0;
    if ((TIMEOUT != 0) && owb_stb && own_cyc && !owb_ack && !owb_err)
      wd_d = wd_q + 1'b1;
  end

  // State registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q  <= 1'b0;
      own_q  <= '0;
      last_q <= IW'(N_MASTERS - 1);
      wd_q   <= '0;
    end else begin
      vld_q  <= vld_d;
      own_q  <= own_d;
      last_q <= last_d;
      wd_q   <= wd_d;
    end
  end

  // Shared-bus mux from the current owner; everything low when idle
  always_comb begin
    owb_cyc     = 1'b0;
    owb_stb     = 1'b0;
    owb_we      = 1'b0;
    owb_4_burst = 1'b0;
    owb_8_burst = 1'b0;
    owb_adr     = '0;
    owb_o_dat   = '0;
    owb_sel     = '0;
    o_grant     = '0;
    if (vld_q) begin
      owb_cyc     = own_cyc;
      owb_stb     = i_wb_stb[own_q] & ~wd_fire;
      owb_we      = i_wb_we[own_q];
      owb_4_burst = i_wb_4_burst[own_q];
      owb_8_burst = i_wb_8_burst[own_q];
      owb_adr     = i_wb_adr[int'(own_q)*ADDR_W +: ADDR_W];
      owb_o_dat   = i_wb_o_dat[int'(own_q)*DATA_W +: DATA_W];
      owb_sel     = i_wb_sel[int'(own_q)*SEL_W +: SEL_W];
      o_grant[own_q] = 1'b1;
    end
  end

  // Per-master termination: only the owner sees ack/err
  for (genvar g = 0; g < N_MASTERS; g++) begin : g_term
    logic is_own;
    assign is_own      = vld_q && (own_q == IW'(g));
    assign o_wb_ack[g] = is_own && owb_ack;
    assign o_wb_err[g] = is_own && (owb_err || wd_fire);
  end

  assign o_timeout = wd_fire;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: three instances (round-robin/TIMEOUT=4,
// fixed-priority/TIMEOUT=255, round-robin/watchdog off) share one stimulus
// and are compared every cycle against an owner/last/wait-count model, plus
// directed checks of the key scenarios.
module tb_wb_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int SW = 2;
  localparam int NI = 3;
  localparam int PM [NI] = '{0, 1, 0};
  localparam int TO [NI] = '{4, 255, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  cyc, stb, we, b4, b8;
  logic [N*AW-1:0] adr;
  logic [N*DW-1:0] dat;
  logic [N*SW-1:0] sel;
  logic          ack, err;

  logic [N-1:0]  ack_o [NI];
  logic [N-1:0]  err_o [NI];
  logic [N-1:0]  gnt_o [NI];
  logic          ocyc [NI], ostb [NI], owe [NI], ob4 [NI], ob8 [NI], oto [NI];
  logic [AW-1:0] oadr [NI];
  logic [DW-1:0] odat [NI];
  logic [SW-1:0] osel [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    wb_rr_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW),
                    .PRIO_MODE(PM[g]), .TIMEOUT(TO[g])) u_dut (
      .i_clk(clk), .i_rst(rst),
      .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
      .i_wb_4_burst(b4), .i_wb_8_burst(b8),
      .i_wb_adr(adr), .i_wb_o_dat(dat), .i_wb_sel(sel),
      .o_wb_ack(ack_o[g]), .o_wb_err(err_o[g]),
      .owb_cyc(ocyc[g]), .owb_stb(ostb[g]), .owb_we(owe[g]),
      .owb_4_burst(ob4[g]), .owb_8_burst(ob8[g]),
      .owb_adr(oadr[g]), .owb_o_dat(odat[g]), .owb_sel(osel[g]),
      .owb_ack(ack), .owb_err(err),
      .o_grant(gnt_o[g]), .o_timeout(oto[g])
    );
  end

  // Reference model: owner index (-1 = idle), last winner, stalled-strobe count
  int own [NI];
  int last [NI];
  int cnt [NI];
  int total = 0, passed = 0, fails = 0;

  task automatic chk(string tag, int c, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  function automatic bit fires(int c);
    return (TO[c] != 0) && (own[c] >= 0) && (cnt[c] == TO[c]);
  endfunction

  task automatic check_model();
    logic [N-1:0] eg, ea, ee;
    logic [5:0]   ectl;
    logic [AW+DW+SW-1:0] edat;
    bit f;
    for (int c = 0; c < NI; c++) begin
      eg = '0; ea = '0; ee = '0; ectl = '0; edat = '0;
      f = fires(c);
      if (own[c] >= 0) begin
        eg[own[c]] = 1'b1;
        ea[own[c]] = ack;
        ee[own[c]] = err | f;
        ectl = {cyc[own[c]], stb[own[c]] & ~f, we[own[c]], b4[own[c]], b8[own[c]], f};
        edat = {adr[own[c]*AW +: AW], dat[own[c]*DW +: DW], sel[own[c]*SW +: SW]};
      end
      chk("grant", c, gnt_o[c], eg);
      chk("ack", c, ack_o[c], ea);
      chk("err", c, err_o[c], ee);
      chk("ctl", c, {ocyc[c], ostb[c], owe[c], ob4[c], ob8[c], oto[c]}, ectl);
      chk("bus", c, {oadr[c], odat[c], osel[c]}, edat);
    end
  endtask

  task automatic model_update();
    int w;
    for (int c = 0; c < NI; c++) begin
      if (rst) begin
        own[c] = -1; last[c] = N - 1; cnt[c] = 0;
      end else begin
        if (own[c] >= 0 && cyc[own[c]] && stb[own[c]] && !fires(c) && !ack && !err)
          cnt[c] = cnt[c] + 1;
        else
          cnt[c] = 0;
        if (own[c] < 0 || !cyc[own[c]]) begin
          w = -1;
          if (PM[c] != 0) begin
            for (int i = 0; i < N; i++) if (cyc[i]) begin w = i; break; end
          end else begin
            for (int k = 1; k <= N; k++)
              if (cyc[(last[c] + k) % N]) begin w = (last[c] + k) % N; break; end
          end
          own[c] = w;
          if (w >= 0) last[c] = w;
        end
      end
    end
  endtask

  // One clock cycle: check settled outputs, advance the model at the edge
  task automatic step();
    #1 check_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    int ord [5];
    bit seen;
    ord = '{0, 1, 2, 3, 0};
    cyc = '0; stb = '0; we = '0; b4 = '0; b8 = '0;
    adr = {$urandom, $urandom, $urandom};
    dat = {$urandom, $urandom};
    sel = 8'(($urandom));
    ack = 1'b1; err = 1'b1; rst = 1'b1;
    cyc = '1; stb = '1;
    @(posedge clk); model_update(); @(negedge clk);

    // reset state: nothing granted, no termination forwarded
    for (int c = 0; c < NI; c++) begin
      #1;
      chk("rst_grant", c, gnt_o[c], 0);
      chk("rst_ack", c, ack_o[c], 0);
      chk("rst_err", c, err_o[c], 0);
      chk("rst_cyc", c, ocyc[c], 0);
    end
    step();

    // masters 0 and 2 together: 0 first, one idle cycle, then 2
    rst = 0; ack = 0; err = 0;
    cyc = 4'b0101; stb = 4'b0101;
    step();
    #1 chk("m0_first", 0, gnt_o[0], 4'b0001);
    step();
    cyc[0] = 0;
    #1 chk("gap_grant", 0, gnt_o[0], 4'b0001);
    chk("gap_cyc", 0, ocyc[0], 0);
    step();
    #1 chk("m2_next", 0, gnt_o[0], 4'b0100);
    step();

    // round-robin fairness: three acked transfers each, order 0,1,2,3,0
    rst = 1; step(); rst = 0;
    cyc = '1; stb = '1; ack = 1;
    step();
    for (int j = 0; j < 5; j++) begin
      for (int t = 0; t < 3; t++) begin
        #1 chk("rr_grant", ord[j], gnt_o[0], 64'd1 << ord[j]);
        chk("rr_ack", ord[j], ack_o[0], 64'd1 << ord[j]);
        step();
      end
      cyc[ord[j]] = 0;
      #1 chk("rr_gap", ord[j], ocyc[0], 0);
      step();
      cyc[ord[j]] = 1;
    end

    // fixed priority: master 3's 8-burst is not split by master 1
    rst = 1; step(); rst = 0;
    cyc = 4'b1000; stb = 4'b1000; b8 = 4'b1000; ack = 1;
    step();
    for (int t = 0; t < 8; t++) begin
      if (t == 3) begin cyc[1] = 1; stb[1] = 1; end
      #1 chk("fp_hold", t, gnt_o[1], 4'b1000);
      chk("fp_ack", t, ack_o[1], 4'b1000);
      step();
    end
    cyc[3] = 0; stb[3] = 0; b8 = '0;
    #1 chk("fp_gap", 1, ocyc[1], 0);
    step();
    #1 chk("fp_m1", 1, gnt_o[1], 4'b0010);
    step();

    // watchdog TIMEOUT=4: err/timeout on the 5th stalled strobe cycle only
    rst = 1; step(); rst = 0;
    cyc = 4'b0001; stb = 4'b0001; ack = 0; err = 0;
    step();
    for (int s = 1; s <= 6; s++) begin
      #1 chk("wd_err", s, err_o[0], (s == 5) ? 4'b0001 : 4'b0000);
      chk("wd_pulse", s, oto[0], (s == 5) ? 1 : 0);
      chk("wd_stb", s, ostb[0], (s == 5) ? 0 : 1);
      step();
    end

    // watchdog disabled: 1000 stalled cycles never produce err/timeout
    seen = 0;
    for (int s = 0; s < 1000; s++) begin
      #1 if (err_o[2] != '0 || oto[2]) seen = 1;
      step();
    end
    chk("no_wd", 2, seen, 0);

    // reset during master 1's burst
    rst = 1; step(); rst = 0;
    cyc = 4'b0010; stb = 4'b0010; b4 = 4'b0010; ack = 1;
    step();
    #1 chk("rb_grant", 0, gnt_o[0], 4'b0010);
    step(); step();
    rst = 1; step(); rst = 0;
    cyc = 4'b0011; stb = 4'b0011;
    #1 chk("rb_cleared", 0, gnt_o[0], 0);
    chk("rb_cyc", 0, ocyc[0], 0);
    chk("rb_noack", 0, ack_o[0], 0);
    step();
    #1 chk("rb_m0", 0, gnt_o[0], 4'b0001);
    step();
    b4 = '0;

    // randomized traffic against the model
    for (int s = 0; s < 500; s++) begin
      if ($urandom_range(0, 3) == 0) cyc = 4'($urandom);
      stb = 4'($urandom); we = 4'($urandom);
      b4 = 4'($urandom); b8 = 4'($urandom);
      adr = {$urandom, $urandom, $urandom};
      dat = {$urandom, $urandom};
      sel = 8'($urandom);
      ack = ($urandom_range(0, 3) == 0);
      err = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Parametrised N-master Wishbone bus arbiter with selectable round-robin or fixed-priority grant, cycle-level bus hold for bursts, and a per-transfer timeout watchdog that terminates hung slave accesses with an error. It is the successor to the two-master data/fetch arbiter in the upper core. It sits between the caches and any additional masters (for example DMA or a debug port) and the single external Wishbone port.

## Interface
- N_MASTERS, 4, number of requesting masters (2..8)
- ADDR_W, 24, Wishbone address width
- DATA_W, 16, Wishbone data width
- SEL_W, 2, byte-select width
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
- TIMEOUT, 255, cycles a strobe may wait for ack/err before forced error; 0 disables the watchdog
- i_clk  in  1  single clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_wb_cyc  in  N_MASTERS  per-master cyc
- i_wb_stb, i_wb_we, i_wb_4_burst, i_wb_8_burst  in  N_MASTERS each  per-master control
- i_wb_adr  in  N_MASTERS*ADDR_W  flattened addresses; master m at bits [m*ADDR_W +: ADDR_W]
- i_wb_o_dat  in  N_MASTERS*DATA_W  flattened write data
- i_wb_sel  in  N_MASTERS*SEL_W  flattened byte selects
- o_wb_ack, o_wb_err  out  N_MASTERS  per-master termination
- owb_cyc, owb_stb, owb_we, owb_4_burst, owb_8_burst  out  1  shared bus control
- owb_adr  out  ADDR_W;  owb_o_dat  out  DATA_W;  owb_sel  out  SEL_W
- owb_ack, owb_err  in  1  slave termination
- o_grant  out  N_MASTERS  one-hot current owner; 0 when idle
- o_timeout  out  1  one-cycle pulse when the watchdog fires

Read data is broadcast to all masters outside this block and is not routed here.

## Operation
- State: grant register (one-hot, plus valid bit), round-robin pointer `last`, and watchdog counter of width clog2(TIMEOUT+1).
- IDLE (grant invalid):
  - At each edge, if any i_wb_cyc is high, grant the winner.
  - Round-robin: the first requesting index searched cyclically from last+1.
  - Fixed priority: the lowest requesting index.
  - `last` is updated to the winner.
- OWNED:
  - The grant is held while the owner's i_wb_cyc is high, regardless of other requests. Bursts (4/8) are therefore never split.
  - Other masters' requests are ignored until release.
- Release:
  - Occurs at the edge where the owner's i_wb_cyc is sampled low.
  - The arbiter selects the next winner in the same edge, with the same rules as IDLE. The releasing master is eligible only if no other master requests (round-robin) or by index (fixed).
  - If there are no requests, the arbiter returns to IDLE.
- Output muxing (combinational from grant):
  - owb_cyc = valid & owner cyc; owb_stb = valid & owner stb & ~watchdog_fire.
  - Remaining outputs come from the owner. When idle, all outputs are 0.
- Termination routing:
  - o_wb_ack[owner] = owb_ack.
  - o_wb_err[owner] = owb_err | watchdog_fire.
  - Non-owners always see 0.
- Watchdog:
  - The counter increments each cycle owb_stb is high with owb_ack=owb_err=0.
  - It clears on ack, err, stb low, release, or reset.
  - watchdog_fire = (TIMEOUT≠0) & (counter==TIMEOUT). On fire, o_timeout pulses for one cycle and the counter clears.
- Simultaneous owb_ack and watchdog_fire: ack is delivered, err is also delivered; the owner treats err as dominant.

## Timing
- Reset values:
  - o_grant=0, all owb_* outputs=0, o_wb_ack=o_wb_err=0, o_timeout=0.
  - counter=0; `last`=N_MASTERS-1, so master 0 wins the first round-robin.
- Reset mid-transaction: the grant is cleared at that edge, so owb_cyc is low in the following cycle. No ack is forwarded after reset.
- Grant latency: cyc rises in cycle t; the master is on the bus in cycle t+1.
- Handover: the owner drops cyc in cycle k; owb_cyc=0 in cycle k; the next owner drives the bus in cycle k+1. There is exactly one idle cycle.
- Ack/err pass-through is zero-latency (combinational).
- Watchdog: a strobe unacked for TIMEOUT cycles gets err in cycle TIMEOUT+1 of the wait, i.e. the TIMEOUT-th count value.

## Test plan
- Reset, then master 0 and master 2 raise cyc together (N=4, PRIO_MODE=0):
  - o_grant=0001 next cycle.
  - After master 0 drops cyc: one idle cycle, then o_grant=0100.
- Round-robin fairness: all 4 masters hold requests, each releasing after 3 acked transfers → grant order 0,1,2,3,0 with a 1-cycle gap each.
- Fixed priority (PRIO_MODE=1): master 3 owns the bus, master 1 requests mid-burst → master 3 keeps the grant through its 8-burst (8 acks), then master 1 is granted.
- Timeout (TIMEOUT=4): owner strobes, slave never acks → o_wb_err[owner] and o_timeout high for exactly one cycle at the 5th stb cycle; owb_stb low in that cycle.
- TIMEOUT=0: strobe held 1000 cycles with no ack → no err and no o_timeout.
- Reset asserted during master 1's burst → owb_cyc=0 and o_grant=0 the next cycle; master 0 then wins the first round-robin arbitration.
